can_rx_destuff: RTL and testbench
=================================

// Module: can_rx_destuff
// PURPOSE
//   CAN 2.0A receive path, the counterpart of the bit-stuffing transmitter.
//   Samples the bus once per bit on a baud enable and removes stuff bits.
//   Deserializes standard frames, checks CRC-15, stuffing and form.
//   Requests the ACK slot and hands the decoded ID, DLC and data to the
//   controller core.
// PARAMETERS
//   IDLE_BITS  11  consecutive recessive bits that define bus idle
//   EOF_BITS   7   recessive bits in the end-of-frame field
//   STUFF_RUN  5   equal-bit run length after which a stuff bit follows
// PORTS
//   clk         in   1   system clock
//   rst_n       in   1   asynchronous reset, active low
//   baud_tick   in   1   one-clk pulse at the bit sample point, sync to clk
//   rx          in   1   bus level (1 = recessive), synchronized upstream
//   rxing       out  1   high from the SOF sample until EOF end or error
//   ack_drive   out  1   request to drive dominant during the ACK slot
//   rx_address  out  11  received identifier
//   rx_rtr      out  1   received RTR bit
//   rx_dlc      out  4   received DLC field, raw value
//   rx_data     out  64  data, byte0 in [63:56], unused bytes zero
//   rx_valid    out  1   one-clk pulse when a good frame completes
//   stuff_err   out  1   one-clk pulse: stuff violation
//   crc_err     out  1   one-clk pulse: CRC mismatch
//   form_err    out  1   one-clk pulse: dominant in a fixed recessive field
// BEHAVIOUR
// - Reset values: all outputs 0; FSM goes to IDLE; counters and CRC are 0.
// - All state changes happen only on clk edges where baud_tick = 1.
// - FSM states: IDLE, WAIT_SOF, ARB, CTRL, DATA, CRC, CRC_DEL, ACK,
//   ACK_DEL, EOF, ERROR.
// - IDLE: count recessive bits; any dominant bit clears the count.
//   At IDLE_BITS recessive bits, go to WAIT_SOF.
// - WAIT_SOF: a dominant bit is SOF. Set rxing, clear the CRC, go to ARB.
// - ARB: 11 ID bits MSB first, then RTR (12 bits).
// - CTRL: IDE, r0, DLC[3:0] (6 bits). IDE = 1 is a form error.
// - Byte count: 0 if RTR = 1, else min(DLC, 8). If 0, go straight to CRC.
// - DATA: 8 x byte-count bits, MSB first, into rx_data from bit 63 down.
// - CRC: receive 15 bits into a separate register.
// - Destuffing runs from SOF through the last CRC bit only:
//   - Track the run length and value of the last bit. A stuff bit also
//     counts, so the run restarts at 1 with the stuff bit's value.
//   - After STUFF_RUN equal bits, the next bit is a stuff bit. It is
//     dropped from the field and from the CRC.
//   - If the stuff bit equals the run value, pulse stuff_err and go to ERROR.
// - CRC-15: polynomial 0x4599, init 0. Covers destuffed bits from SOF
//   through the last data bit.
// - CRC_DEL: 1 bit, must be recessive.
//   - Dominant: form_err, go to ERROR.
//   - CRC mismatch: crc_err, go to ERROR. Mismatch wins if both occur.
//   - Otherwise set ack_drive.
// - ACK: clear ack_drive at the tick that samples the ACK slot. The slot
//   value is ignored (receiver only).
// - ACK_DEL: 1 bit, must be recessive. Dominant gives form_err.
// - EOF: EOF_BITS bits, all recessive. On the last one, pulse rx_valid,
//   clear rxing, go to WAIT_SOF (EOF plus 3-bit intermission = idle).
//   - Dominant bit before the last: form_err.
//   - Dominant last bit: overload. No error, frame accepted.
// - ERROR: clear rxing and ack_drive, go to IDLE. rx_* fields are not
//   updated and rx_valid does not pulse.
// - Output holding: rx_address, rx_rtr, rx_dlc and rx_data update
//   together in the rx_valid cycle. They hold until the next good frame.
// - An error pulse occurs in the same clk as the offending baud_tick.
//   At most one error pulse per frame.
// - Reset mid-frame: abort immediately, no pulses, FSM in IDLE.
// TESTING
// - After IDLE_BITS recessive bits: ID 0x123, DLC 1, data 0xA5, CRC from
//   the bench model -> rx_valid once; rx_address 0x123, rx_dlc 1,
//   rx_data 0xA500_0000_0000_0000; ack_drive high exactly one bit time.
// - ID 0x000, DLC 8, data all 0x00 (heavy stuffing) -> rx_valid;
//   rx_data 0; no stuff_err.
// - Same frame with one stuff bit inverted -> stuff_err at that tick;
//   no rx_valid; previous rx_* values held.
// - Flip one data bit of frame 1 -> crc_err at the CRC_DEL tick;
//   ack_drive stays 0.
// - Dominant bit at EOF bit 3 -> form_err.
//   DLC 0xF with data 8 x 0x5A -> 8 bytes received, rx_dlc 0xF.
// - rst_n low mid-DATA -> all outputs 0 at once; the next clean frame
//   after idle decodes correctly.

Source files
------------

// File: rtl/can_rx_destuff.sv
// can_rx_destuff: CAN 2.0A standard-frame receiver with bit destuffing, CRC-15, form checks and ACK request.
//   clk, rst_n   clock, asynchronous active-low reset
//   baud_tick    one-clk strobe at the bit sample point; all state advances only on it
//   rx           synchronized bus level (1 = recessive)
//   rxing        frame reception in progress (SOF until EOF end or error)
//   ack_drive    request to drive dominant during the ACK slot
//   rx_address, rx_rtr, rx_dlc, rx_data  fields of the last good frame, updated with rx_valid
//   rx_valid, stuff_err, crc_err, form_err  one-clk pulses
module can_rx_destuff #(
  parameter int IDLE_BITS = 11,
  parameter int EOF_BITS  = 7,
  parameter int STUFF_RUN = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        baud_tick,
  input  logic        rx,
  output logic        rxing,
  output logic        ack_drive,
  output logic [10:0] rx_address,
  output logic        rx_rtr,
  output logic [3:0]  rx_dlc,
  output logic [63:0] rx_data,
  output logic        rx_valid,
  output logic        stuff_err,
  output logic        crc_err,
  output logic        form_err
);
  typedef enum logic [3:0] {IDLE, WAIT_SOF, ARB, CTRL, DATA, CRC, CRC_DEL, ACK, ACK_DEL, EOF, ERROR} state_t;
  localparam logic [6:0] IDLE_LAST = 7'(IDLE_BITS - 1);
  localparam logic [6:0] EOF_LAST  = 7'(EOF_BITS - 1);
  localparam logic [2:0] RUN       = 3'(STUFF_RUN);
  state_t      state, state_n;
  logic [6:0]  cnt, cnt_n;
  logic [2:0]  run_len, run_len_n;
  logic        run_val, run_val_n;
  logic [14:0] crc, crc_n, crc_rx, crc_rx_n, crc_upd;
  logic [11:0] arb, arb_n;
  logic [2:0]  ctrl, ctrl_n;
  logic [3:0]  dlc, dlc_n, dlc_w, nbytes, nbytes_n;
  logic [63:0] data, data_n;
  logic        rxing_n, ack_n, valid_n, stuff_n, crc_err_n, form_n;
  logic        destuff, is_stuff;
  assign destuff  = state inside {ARB, CTRL, DATA, CRC};
  assign is_stuff = destuff && run_len == RUN;
  assign crc_upd  = {crc[13:0], 1'b0} ^ ((rx ^ crc[14]) ? 15'h4599 : 15'h0);
  assign dlc_w    = {ctrl, rx};
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    run_len_n = run_len;
    run_val_n = run_val;
    crc_n = crc;
    crc_rx_n = crc_rx;
    arb_n = arb;
    ctrl_n = ctrl;
    dlc_n = dlc;
    nbytes_n = nbytes;
    data_n = data;
    rxing_n = rxing;
    ack_n = ack_drive;
    valid_n = 1'b0;
    stuff_n = 1'b0;
    crc_err_n = 1'b0;
    form_n = 1'b0;
    if (is_stuff) begin
      // stuff bit is dropped from field and CRC but starts a new run of its own value
      run_len_n = 3'd1;
      run_val_n = rx;
      stuff_n = rx == run_val;
    end else begin
      if (destuff) begin
        run_len_n = rx == run_val ? run_len + 3'd1 : 3'd1;
        run_val_n = rx;
      end
      if (state inside {ARB, CTRL, DATA}) crc_n = crc_upd;
      case (state)
        IDLE: begin
          cnt_n = rx ? cnt + 7'd1 : 7'd0;
          if (rx && cnt == IDLE_LAST) begin
            state_n = WAIT_SOF;
            cnt_n = '0;
          end
        end
        WAIT_SOF: if (!rx) begin
          // SOF: a dominant bit fed into a zero CRC leaves it zero, so clearing covers it
          state_n = ARB;
          rxing_n = 1'b1;
          crc_n = '0;
          cnt_n = '0;
          run_len_n = 3'd1;
          run_val_n = 1'b0;
          data_n = '0;
        end
        ARB: begin
          arb_n = {arb[10:0], rx};
          cnt_n = cnt + 7'd1;
          if (cnt == 7'd11) begin
            state_n = CTRL;
            cnt_n = '0;
          end
        end
        CTRL: begin
          ctrl_n = {ctrl[1:0], rx};
          cnt_n = cnt + 7'd1;
          form_n = cnt == 7'd0 && rx;
          if (cnt == 7'd5) begin
            dlc_n = dlc_w;
            nbytes_n = arb[0] ? 4'd0 : (dlc_w > 4'd8 ? 4'd8 : dlc_w);
            state_n = (arb[0] || dlc_w == 4'd0) ? CRC : DATA;
            cnt_n = '0;
          end
        end
        DATA: begin
          data_n[~cnt[5:0]] = rx;
          cnt_n = cnt + 7'd1;
          if (cnt == {nbytes, 3'b000} - 7'd1) begin
            state_n = CRC;
            cnt_n = '0;
          end
        end
        CRC: begin
          crc_rx_n = {crc_rx[13:0], rx};
          cnt_n = cnt + 7'd1;
          if (cnt == 7'd14) begin
            state_n = CRC_DEL;
            cnt_n = '0;
          end
        end
        CRC_DEL: begin
          crc_err_n = crc_rx != crc;
          form_n = crc_rx == crc && !rx;
          ack_n = crc_rx == crc && rx;
          state_n = ACK;
        end
        ACK: begin
          ack_n = 1'b0;
          state_n = ACK_DEL;
        end
        ACK_DEL: begin
          form_n = !rx;
          state_n = EOF;
          cnt_n = '0;
        end
        EOF: begin
          cnt_n = cnt + 7'd1;
          valid_n = cnt == EOF_LAST;
          form_n = cnt != EOF_LAST && !rx;
          if (valid_n) begin
            state_n = WAIT_SOF;
            rxing_n = 1'b0;
            cnt_n = '0;
          end
        end
        default: begin
          state_n = IDLE;
          rxing_n = 1'b0;
          ack_n = 1'b0;
          cnt_n = '0;
        end
      endcase
    end
    if (stuff_n || crc_err_n || form_n) begin
      state_n = ERROR;
      rxing_n = 1'b0;
      ack_n = 1'b0;
      cnt_n = '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      run_len <= '0;
      run_val <= 1'b0;
      crc <= '0;
      crc_rx <= '0;
      arb <= '0;
      ctrl <= '0;
      dlc <= '0;
      nbytes <= '0;
      data <= '0;
      rxing <= 1'b0;
      ack_drive <= 1'b0;
      rx_address <= '0;
      rx_rtr <= 1'b0;
      rx_dlc <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      stuff_err <= 1'b0;
      crc_err <= 1'b0;
      form_err <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      stuff_err <= 1'b0;
      crc_err <= 1'b0;
      form_err <= 1'b0;
      if (baud_tick) begin
        state <= state_n;
        cnt <= cnt_n;
        run_len <= run_len_n;
        run_val <= run_val_n;
        crc <= crc_n;
        crc_rx <= crc_rx_n;
        arb <= arb_n;
        ctrl <= ctrl_n;
        dlc <= dlc_n;
        nbytes <= nbytes_n;
        data <= data_n;
        rxing <= rxing_n;
        ack_drive <= ack_n;
        rx_valid <= valid_n;
        stuff_err <= stuff_n;
        crc_err <= crc_err_n;
        form_err <= form_n;
        if (valid_n) begin
          rx_address <= arb[11:1];
          rx_rtr <= arb[0];
          rx_dlc <= dlc;
          rx_data <= data;
        end
      end
    end
  end
endmodule

// File: tb/tb_can_rx_destuff.sv
// tb_can_rx_destuff: directed frames against can_rx_destuff with a bench-side frame builder and CRC model.
module tb_can_rx_destuff;
  logic        clk = 1'b0;
  logic        rst_n, baud_tick, rx;
  logic        rxing, ack_drive, rx_rtr, rx_valid, stuff_err, crc_err, form_err;
  logic [10:0] rx_address;
  logic [3:0]  rx_dlc;
  logic [63:0] rx_data;
  int n_checks = 0, n_err = 0;
  int n_valid, n_stuff, n_crc, n_form, n_ack, ack_at, err_at, bit_idx, exp_at;
  logic fr[$];
  int sidx[$];
  int crcdel;
  can_rx_destuff dut (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .rx(rx),
    .rxing(rxing), .ack_drive(ack_drive), .rx_address(rx_address), .rx_rtr(rx_rtr),
    .rx_dlc(rx_dlc), .rx_data(rx_data), .rx_valid(rx_valid),
    .stuff_err(stuff_err), .crc_err(crc_err), .form_err(form_err)
  );
  always #5 clk = ~clk;
  initial begin
    #5_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic send_bit(input logic b);
    @(negedge clk);
    rx = b;
    baud_tick = 1'b1;
    @(negedge clk);
    baud_tick = 1'b0;
    if (rx_valid) n_valid++;
    if (stuff_err) n_stuff++;
    if (crc_err) n_crc++;
    if (form_err) n_form++;
    if (ack_drive) begin
      n_ack++;
      if (ack_at < 0) ack_at = bit_idx;
    end
    if ((stuff_err || crc_err || form_err) && err_at < 0) err_at = bit_idx;
    bit_idx++;
    @(negedge clk);
  endtask
  task automatic idle();
    repeat (11) send_bit(1'b1);
  endtask
  task automatic build(input logic [10:0] id, input logic rtr, input logic [3:0] dlc,
                       input logic [63:0] d, input int flip);
    logic raw[$];
    logic [14:0] c = '0;
    logic nxt, last;
    int nb, run;
    raw.push_back(1'b0);
    for (int i = 10; i >= 0; i--) raw.push_back(id[i]);
    raw.push_back(rtr);
    raw.push_back(1'b0);
    raw.push_back(1'b0);
    for (int i = 3; i >= 0; i--) raw.push_back(dlc[i]);
    nb = rtr ? 0 : (dlc > 4'd8 ? 8 : int'(dlc));
    for (int i = 0; i < nb * 8; i++) raw.push_back(d[63 - i]);
    foreach (raw[i]) begin
      nxt = raw[i] ^ c[14];
      c = {c[13:0], 1'b0};
      if (nxt) c = c ^ 15'h4599;
    end
    if (flip >= 0) raw[flip] = ~raw[flip];
    for (int i = 14; i >= 0; i--) raw.push_back(c[i]);
    fr.delete();
    sidx.delete();
    run = 0;
    last = 1'b1;
    foreach (raw[i]) begin
      if (run == 5) begin
        fr.push_back(~last);
        sidx.push_back(fr.size() - 1);
        last = ~last;
        run = 1;
      end
      fr.push_back(raw[i]);
      if (raw[i] == last) run++;
      else begin
        run = 1;
        last = raw[i];
      end
    end
    crcdel = fr.size();
    repeat (13) fr.push_back(1'b1);
  endtask
  task automatic send_frame(input int nbits);
    int n;
    n = nbits < 0 ? fr.size() : nbits;
    n_valid = 0; n_stuff = 0; n_crc = 0; n_form = 0; n_ack = 0;
    ack_at = -1; err_at = -1; bit_idx = 0;
    for (int i = 0; i < n; i++) send_bit(fr[i]);
  endtask
  initial begin
    rst_n = 1'b0;
    baud_tick = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_flags", {rxing, ack_drive, rx_rtr, rx_valid, stuff_err, crc_err, form_err}, 0);
    check("reset_addr", rx_address, 0);
    check("reset_dlc", rx_dlc, 0);
    check("reset_data", rx_data, 0);
    rst_n = 1'b1;
    idle();
    build(11'h123, 1'b0, 4'd1, 64'hA500_0000_0000_0000, -1);
    send_frame(-1);
    check("f1_valid", n_valid, 1);
    check("f1_addr", rx_address, 11'h123);
    check("f1_rtr", rx_rtr, 0);
    check("f1_dlc", rx_dlc, 1);
    check("f1_data", rx_data, 64'hA500_0000_0000_0000);
    check("f1_ack_bits", n_ack, 1);
    check("f1_ack_at", ack_at, crcdel);
    check("f1_no_err", err_at, -1);
    check("f1_rxing_end", rxing, 0);
    build(11'h000, 1'b0, 4'd8, 64'h0, -1);
    fr[sidx[2]] = ~fr[sidx[2]];
    exp_at = sidx[2];
    send_frame(-1);
    check("se_count", n_stuff, 1);
    check("se_at", err_at, exp_at);
    check("se_no_valid", n_valid, 0);
    check("se_other_err", n_crc + n_form, 0);
    check("se_hold_addr", rx_address, 11'h123);
    check("se_hold_data", rx_data, 64'hA500_0000_0000_0000);
    idle();
    build(11'h000, 1'b0, 4'd8, 64'h0, -1);
    send_frame(-1);
    check("zero_valid", n_valid, 1);
    check("zero_no_stuff_err", n_stuff, 0);
    check("zero_addr", rx_address, 0);
    check("zero_dlc", rx_dlc, 8);
    check("zero_data", rx_data, 0);
    build(11'h123, 1'b0, 4'd1, 64'hA500_0000_0000_0000, 22);
    send_frame(-1);
    check("ce_count", n_crc, 1);
    check("ce_at", err_at, crcdel);
    check("ce_no_ack", n_ack, 0);
    check("ce_no_valid", n_valid, 0);
    idle();
    build(11'h123, 1'b0, 4'd1, 64'hA500_0000_0000_0000, -1);
    fr[crcdel + 5] = 1'b0;
    send_frame(-1);
    check("eof_form_count", n_form, 1);
    check("eof_form_at", err_at, crcdel + 5);
    check("eof_form_no_valid", n_valid, 0);
    idle();
    build(11'h321, 1'b0, 4'd1, 64'h3C00_0000_0000_0000, -1);
    fr[crcdel + 9] = 1'b0;
    send_frame(-1);
    check("ovl_valid", n_valid, 1);
    check("ovl_no_form", n_form, 0);
    check("ovl_addr", rx_address, 11'h321);
    build(11'h7F0, 1'b0, 4'hF, 64'h5A5A_5A5A_5A5A_5A5A, -1);
    send_frame(-1);
    check("dlcf_valid", n_valid, 1);
    check("dlcf_dlc", rx_dlc, 4'hF);
    check("dlcf_data", rx_data, 64'h5A5A_5A5A_5A5A_5A5A);
    check("dlcf_addr", rx_address, 11'h7F0);
    build(11'h555, 1'b1, 4'd4, 64'h0, -1);
    send_frame(-1);
    check("rtr_valid", n_valid, 1);
    check("rtr_bit", rx_rtr, 1);
    check("rtr_dlc", rx_dlc, 4);
    check("rtr_data", rx_data, 0);
    check("rtr_addr", rx_address, 11'h555);
    build(11'h123, 1'b0, 4'd1, 64'hA500_0000_0000_0000, -1);
    send_frame(24);
    check("mid_rxing", rxing, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_flags", {rxing, ack_drive, rx_rtr, rx_valid, stuff_err, crc_err, form_err}, 0);
    check("mid_rst_addr", rx_address, 0);
    check("mid_rst_dlc", rx_dlc, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    send_frame(-1);
    check("post_rst_valid", n_valid, 1);
    check("post_rst_addr", rx_address, 11'h123);
    check("post_rst_data", rx_data, 64'hA500_0000_0000_0000);
    check("post_rst_no_err", err_at, -1);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
